// File: rtl/cell_link_tx.sv
// Serial link transmitter: buffers W-bit words in a small FIFO and sends each
// as a framed bit stream (start 1, data LSB first, even parity, gap 0).
module cell_link_tx #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     link_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, GAP} state_t;

    state_t          state_q, state_d;
    logic            link_q, link_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic            par_q, par_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]    mem_q [DEPTH];

    logic            push;
    logic            pop;

    // Readiness depends on occupancy only, so a full FIFO refuses even during a pop.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign link_out = link_q;
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        link_d   = link_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            IDLE: begin
                link_d = 1'b0;
                if (pop) begin
                    shreg_d  = mem_q[rd_ptr_q];
                    par_d    = ^mem_q[rd_ptr_q];
                    link_d   = 1'b1;
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                link_d   = shreg_q[0];
                shreg_d  = {1'b0, shreg_q[W-1:1]};
                bitcnt_d = bitcnt_q + BW'(1);
                if (bitcnt_q == BW'(W - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                link_d  = par_q;
                state_d = GAP;
            end
            GAP: begin
                link_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                link_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            link_q   <= 1'b0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            bitcnt_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            link_q   <= link_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            bitcnt_q <= bitcnt_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_cell_link_tx.sv
// Scoreboard bench for cell_link_tx: pushed words queue expected frames, and a
// negedge monitor rebuilds frames from the line and compares them in order.
module tb_cell_link_tx;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         p;
    } exp_t;

    logic                   clk;
    logic                   reset;
    logic [W-1:0]           in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   link_out;
    logic                   busy;
    logic [$clog2(DEPTH):0] count;

    int   checks;
    int   passes;
    exp_t expq[$];

    cell_link_tx #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .link_out (link_out),
        .busy     (busy),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Offers one word for one edge; queues the expected frame if it was taken.
    task automatic applyStimulus(input logic [W-1:0] d, input logic p);
        logic rdy;
        in_data  = d;
        in_valid = 1'b1;
        rdy      = in_ready;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        if (rdy) begin
            expq.push_back('{d: d, p: p});
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 600 && busy; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("drainIdle", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("sbEmpty", expq.size(), 32'd0);
    endtask

    // Frame reconstruction from the line, sampled on the falling edge.
    int           mState;
    int           mIdx;
    logic [W-1:0] mData;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            mState = 0;
        end else begin
            case (mState)
                0: if (link_out) begin
                    mState = 1;
                    mIdx   = 0;
                    mData  = '0;
                end
                1: begin
                    mData[mIdx] = link_out;
                    if (mIdx == W - 1) mState = 2;
                    mIdx++;
                end
                2: begin
                    if (expq.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL sbUnexpectedFrame: got data %0h with no word queued", mData);
                    end else begin
                        e = expq.pop_front();
                        checkOutput("sbData", {16'd0, mData}, {16'd0, e.d});
                        checkOutput("sbParity", {31'd0, link_out}, {31'd0, e.p});
                    end
                    mState = 3;
                end
                default: begin
                    checkOutput("sbGap", {31'd0, link_out}, 32'd0);
                    mState = 0;
                end
            endcase
        end
    end

    initial begin
        bit [0:18]    t1Bits;
        logic [W-1:0] bpWords [8];
        int           bpEdges [8];
        int           e;
        int           ones;
        logic         rdy;

        checks   = 0;
        passes   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        mState   = 0;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstLink", {31'd0, link_out}, 32'd0);
        checkOutput("rstCount", {29'd0, count}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstReady", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single word 0xA5C3: start, 16 data bits LSB first, parity 0, gap 0.
        t1Bits = 19'b1110000111010010100;
        applyStimulus(16'hA5C3, 1'b0);
        checkOutput("t1NoBypass", {31'd0, link_out}, 32'd0);
        checkOutput("t1Count", {29'd0, count}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #2;
            if (k <= 19) checkOutput($sformatf("t1Bit%0d", k), {31'd0, link_out}, {31'd0, t1Bits[k-1]});
            if (k == 1)  checkOutput("t1BusyHigh", {31'd0, busy}, 32'd1);
            if (k == 20) checkOutput("t1BusyLow", {31'd0, busy}, 32'd0);
        end
        waitIdle();

        // Back-to-back frames; the second push coincides with the first pop at count 1.
        applyStimulus(16'h0001, 1'b1);
        checkOutput("t2CountE0", {29'd0, count}, 32'd1);
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("t4PushPopCount", {29'd0, count}, 32'd1);
        checkOutput("t2Start1", {31'd0, link_out}, 32'd1);
        applyStimulus(16'h8000, 1'b1);
        checkOutput("t2CountE2", {29'd0, count}, 32'd2);
        for (int k = 3; k <= 58; k++) begin
            @(posedge clk);
            #2;
            if (k == 20 || k == 39) checkOutput($sformatf("t2Start%0d", k), {31'd0, link_out}, 32'd1);
            if (k == 18) checkOutput("t2Par1", {31'd0, link_out}, 32'd1);
            if (k == 37) checkOutput("t2Par2", {31'd0, link_out}, 32'd0);
            if (k == 56) checkOutput("t2Par3", {31'd0, link_out}, 32'd1);
            if (k == 57) checkOutput("t2Gap3", {31'd0, link_out}, 32'd0);
        end
        waitIdle();

        // Backpressure: in_valid held high with 8 distinct words.
        bpWords = '{16'h0003, 16'h0007, 16'h1234, 16'hF0F0, 16'h5555, 16'h8001, 16'h00FF, 16'h7FFF};
        bpEdges = '{0, 1, 2, 3, 4, 21, 40, 59};
        e = -1;
        for (int i = 0; i < 8; i++) begin
            in_data  = bpWords[i];
            in_valid = 1'b1;
            do begin
                rdy = in_ready;
                @(posedge clk);
                #2;
                e++;
                if (e == 5)  checkOutput("t3ReadyLowE5", {31'd0, in_ready}, 32'd0);
                if (e == 19) checkOutput("t3ReadyLowE19", {31'd0, in_ready}, 32'd0);
                if (e == 20) checkOutput("t3ReadyHighE20", {31'd0, in_ready}, 32'd1);
            end while (!rdy && e < 300);
            checkOutput($sformatf("t3AcceptEdge%0d", i), e, bpEdges[i]);
            if (rdy) expq.push_back('{d: bpWords[i], p: ^bpWords[i]});
        end
        in_valid = 1'b0;
        waitIdle();

        // Reset during data bit 5 with two words queued.
        applyStimulus(16'hFFFF, 1'b0);
        applyStimulus(16'h1234, 1'b1);
        applyStimulus(16'h5678, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("t5PreResetBit5", {31'd0, link_out}, 32'd1);
        checkOutput("t5PreResetCount", {29'd0, count}, 32'd2);
        reset = 1'b0;
        expq.delete();
        #1;
        checkOutput("t5RstLink", {31'd0, link_out}, 32'd0);
        checkOutput("t5RstCount", {29'd0, count}, 32'd0);
        checkOutput("t5RstBusy", {31'd0, busy}, 32'd0);
        checkOutput("t5RstReady", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        ones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            if (link_out) ones++;
        end
        checkOutput("t5NoFrames", ones, 32'd0);
        checkOutput("t5IdleBusy", {31'd0, busy}, 32'd0);

        // Random soak; the monitor checks every reconstructed frame.
        for (int k = 0; k < 500; k++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = W'($urandom);
            rdy      = in_ready;
            @(posedge clk);
            #2;
            if (in_valid && rdy) expq.push_back('{d: in_data, p: ^in_data});
        end
        in_valid = 1'b0;
        waitIdle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cell_link_tx.md
# cell_link_tx

Serial link transmitter for the cell mesh. It accepts parallel W-bit words on a valid/ready interface, buffers them in a small FIFO, and serializes each word onto a single-bit link in the framed format that a cell's `left_in`/`top_in` inputs consume. It sits at the mesh boundary, feeding operands from the host/ALU side into the edge cells, one instance per edge link.

## Interface

- `W`, default 16: data word width in bits; must be ≥ 2.
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2, ≥ 2.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_data`  input  W  word to transmit.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  FIFO can accept a word; combinational, `count != DEPTH`.
- `link_out`  output  1  serial link line; registered; idle level 0.
- `busy`  output  1  `state != IDLE || count != 0`.
- `count`  output  $clog2(DEPTH)+1  words currently held in the FIFO, excluding the word being shifted.

## Operation

- Frame format is W+3 bits, one bit per clock:
  - start bit 1;
  - W data bits, LSB first;
  - even-parity bit, equal to the XOR of all data bits;
  - one gap bit 0.
- Consecutive frames are back-to-back with no additional idle. The line is 0 whenever no frame is in progress.
- FIFO write: `in_valid && in_ready` at a rising edge pushes `in_data`.
  - `in_ready` depends only on `count`.
  - When the FIFO is full, `in_ready` is 0 even if a pop occurs in the same cycle.
- FIFO read: the serializer pops the head word.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo DEPTH.
- FSM, with `link_out` and state updated together each edge:
  - IDLE:
    - If the FIFO is empty: `link_out` <= 0, stay in IDLE.
    - Otherwise: pop the head into the shift register, latch its parity, `link_out` <= 1, `bitcnt` <= 0, go to DATA.
  - DATA: `link_out` <= `shreg[0]`, shift right, `bitcnt`++. After the cycle with `bitcnt == W-1`, go to PARITY.
  - PARITY: `link_out` <= parity, go to GAP.
  - GAP: `link_out` <= 0, go to IDLE.
- A word pushed into an empty FIFO while the FSM is in IDLE may be popped on the very next edge. It is never popped on the same edge it is written; there is no bypass.
- Reset (asserted, `reset` = 0), applied immediately and asynchronously:
  - `link_out` = 0, state = IDLE, `count` = 0, FIFO pointers = 0, `bitcnt` = 0;
  - `busy` = 0, `in_ready` = 1.
- Reset mid-frame truncates the frame and discards all FIFO contents. The line drops to 0 immediately; the receiver detects the truncation through its length/parity checks.

## Timing

- A word is accepted at edge k with the FIFO empty and the FSM in IDLE. Its bits then appear on `link_out` as follows:
  - start bit after edge k+1;
  - data bit i after edge k+2+i;
  - parity bit after edge k+2+W;
  - gap bit after edge k+3+W.
- Earliest next start bit: after edge k+4+W. The sustained frame period is W+3 cycles.
- Ingress latency from accept to start bit is 1 cycle.
- Throughput: at most one word per W+3 cycles. With the link saturated, the FIFO absorbs DEPTH words plus the one being shifted.
- `count` reflects the pushes and pops of an edge in the cycle following that edge. `in_ready` follows combinationally.
- `busy` falls in the cycle after the GAP edge when the FIFO is empty.

## Test plan

- Single word, W=16, `in_data` = 0xA5C3, accepted at edge 0:
  - start bit after edge 1;
  - data bits after edges 2..17: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
  - parity 0 after edge 18, gap 0 after edge 19;
  - `busy` = 0 from edge 20.
- Back-to-back: push 0x0001, 0xFFFF, 0x8000 on consecutive cycles.
  - Start bits after edges 1, 20 and 39.
  - Parity bits are 1, 0 and 1.
  - The line is never 1 between frames except at start bits.
- Backpressure, DEPTH=4: hold `in_valid` = 1 with 8 distinct words.
  - 5 words are accepted on edges 0–4 (one is popped at edge 1).
  - `in_ready` = 0 from edge 5 until the pop at edge 20. The next accept happens at edge 21.
  - All 8 words are transmitted in order with no loss.
- Simultaneous push/pop at count=1: `count` stays 1 and the data order is preserved.
- Reset asserted during data bit 5 of a frame with 2 words queued:
  - `link_out` = 0 immediately; `count` = 0, `busy` = 0, `in_ready` = 1.
  - After deassertion with no pushes, no further frames appear.
- Random soak: random `in_valid` and data. A scoreboard reconstructs frames from `link_out` and checks data, parity, the gap bit, and order against the pushed words.
